// File: rtl/i2cm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2cm_pkg
// Description : Shared types and constants for the I2C bus monitor: decoder
//               state encoding, display-select codes and event-counter slots.
// Revision    : 1.0 - initial release
// ============================================================================
package i2cm_pkg;

    // Decoder state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ACKB = 2'd3
    } state_e;

    // Display select codes
    localparam logic [2:0] c_sel_scl   = 3'd0;
    localparam logic [2:0] c_sel_sda   = 3'd1;
    localparam logic [2:0] c_sel_start = 3'd2;
    localparam logic [2:0] c_sel_stop  = 3'd3;
    localparam logic [2:0] c_sel_byte  = 3'd4;
    localparam logic [2:0] c_sel_nack  = 3'd5;
    localparam logic [2:0] c_sel_addr  = 3'd6;
    localparam logic [2:0] c_sel_err   = 3'd7;

    // Event counter slots
    localparam int c_n_cnt     = 7;
    localparam int c_idx_scl   = 0;
    localparam int c_idx_sda   = 1;
    localparam int c_idx_start = 2;
    localparam int c_idx_stop  = 3;
    localparam int c_idx_byte  = 4;
    localparam int c_idx_nack  = 5;
    localparam int c_idx_err   = 6;

endpackage
`default_nettype wire

// File: rtl/enc7led.sv
`default_nettype none
// ============================================================================
// Module      : enc7led
// Description : Nibble to seven-segment encoder (active-high, seg[0]=a ..
//               seg[6]=g). With enchx=1 values A-F show as hex letters; with
//               enchx=0 they are blanked (decimal-only display).
// Ports       : din   [3:0] nibble to show
//               enchx       hex enable
//               seg   [6:0] segment drive
// Revision    : 1.0 - initial release
// ============================================================================
module enc7led (
    input  logic [3:0] din,
    input  logic       enchx,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (din)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = enchx ? 7'h77 : 7'h00;
            4'hB: seg = enchx ? 7'h7C : 7'h00;
            4'hC: seg = enchx ? 7'h39 : 7'h00;
            4'hD: seg = enchx ? 7'h5E : 7'h00;
            4'hE: seg = enchx ? 7'h79 : 7'h00;
            default: seg = enchx ? 7'h71 : 7'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/i2cm_line_filt.sv
`default_nettype none
// ============================================================================
// Module      : i2cm_line_filt
// Description : Synchroniser plus glitch filter for one raw bus line. The
//               output only changes after FILT consecutive synchronised
//               samples that all differ from the current output.
// Ports       : clk, rst_n  clock, async active-low reset
//               din         raw asynchronous line
//               dout        filtered line (resets to 1, idle bus)
// Revision    : 1.0 - initial release
// ============================================================================
module i2cm_line_filt #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int c_cw = (FILT > 1) ? $clog2(FILT) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [c_cw-1:0]        cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   w_samp;

    assign w_samp = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d  = '0;
        filt_d = filt_q;
        // Any sample equal to the current output restarts the run.
        if (w_samp != filt_q) begin
            if (cnt_q == c_cw'(FILT - 1)) begin
                filt_d = w_samp;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_monitor
// Description : Oversampling I2C bus analyser. Filters SCL/SDA, decodes
//               START/STOP/bytes/ACK, keeps saturating event counters and a
//               last-transfer capture, and drives a hex seven-segment display.
// Ports       : clk, rst_n        clock, async active-low reset
//               scl, sda          raw bus lines
//               sel [2:0]         display select
//               clr               synchronous counter clear (level)
//               disp_val          registered selected value
//               hxled             seven-segment digits of disp_val
//               bus_busy          START seen, no STOP yet
//               byte_stb          one-cycle pulse per completed byte+ACK
//               last_byte/ack     most recent completed byte and its ACK bit
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_monitor
    import i2cm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   scl,
    input  logic                   sda,
    input  logic [2:0]             sel,
    input  logic                   clr,
    output logic [CNT_W-1:0]       disp_val,
    output logic [CNT_W/4*7-1:0]   hxled,
    output logic                   bus_busy,
    output logic                   byte_stb,
    output logic [7:0]             last_byte,
    output logic                   last_ack
);

    logic w_f_scl, w_f_sda;
    logic p_scl_q, p_sda_q;

    i2cm_line_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_scl (
        .clk(clk), .rst_n(rst_n), .din(scl), .dout(w_f_scl)
    );
    i2cm_line_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_filt_sda (
        .clk(clk), .rst_n(rst_n), .din(sda), .dout(w_f_sda)
    );

    // Bus events. START/STOP need SCL high in both cycles, so an SDA change
    // coinciding with an SCL change is never a condition.
    logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;
    assign w_scl_rise = w_f_scl & ~p_scl_q;
    assign w_scl_fall = ~w_f_scl & p_scl_q;
    assign w_sda_rise = w_f_sda & ~p_sda_q;
    assign w_sda_fall = ~w_f_sda & p_sda_q;
    assign w_start    = w_sda_fall & w_f_scl & p_scl_q;
    assign w_stop     = w_sda_rise & w_f_scl & p_scl_q;

    // Decoder state
    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       rose_q, rose_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] addr_q, addr_d;
    logic       first_q, first_d;
    logic [7:0] last_byte_q, last_byte_d;
    logic       last_ack_q, last_ack_d;
    logic       busy_q, busy_d;
    logic       byte_stb_q, byte_stb_d;
    logic       w_inc_byte, w_inc_nack, w_inc_err;
    logic [3:0] w_bits;

    // A START/STOP is always preceded by an SCL rise that shifted a bit; that
    // rise is the condition's own SCL-high phase, not data, so it is excluded
    // when judging whether the condition interrupted a byte.
    assign w_bits = bit_cnt_q - {3'b000, rose_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rose_d      = rose_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        first_d     = first_q;
        last_byte_d = last_byte_q;
        last_ack_d  = last_ack_q;
        busy_d      = busy_q;
        byte_stb_d  = 1'b0;
        w_inc_byte  = 1'b0;
        w_inc_nack  = 1'b0;
        w_inc_err   = 1'b0;
        if (w_start || w_stop) begin
            w_inc_err = (w_bits != 4'd0);
            bit_cnt_d = 4'd0;
            rose_d    = 1'b0;
            if (w_start) begin
                state_d = ADDR;
                busy_d  = 1'b1;
                first_d = 1'b1;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else begin
            if (w_scl_fall) begin
                rose_d = 1'b0;
            end
            if (w_scl_rise) begin
                case (state_q)
                    ADDR, DATA: begin
                        shreg_d   = {shreg_q[6:0], w_f_sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        rose_d    = 1'b1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ACKB;
                        end
                    end
                    ACKB: begin
                        byte_stb_d  = 1'b1;
                        last_byte_d = shreg_q;
                        last_ack_d  = w_f_sda;
                        w_inc_byte  = 1'b1;
                        w_inc_nack  = w_f_sda;
                        if (first_q) begin
                            addr_d  = shreg_q;
                            first_d = 1'b0;
                        end
                        bit_cnt_d = 4'd0;
                        state_d   = DATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Saturating event counters; clr beats any increment.
    logic [CNT_W-1:0] cnt_q [c_n_cnt];
    logic [CNT_W-1:0] cnt_d [c_n_cnt];
    logic [c_n_cnt-1:0] w_inc;

    assign w_inc = {w_inc_err, w_inc_nack, w_inc_byte, w_stop, w_start,
                    w_sda_rise, w_scl_rise};

    always_comb begin
        for (int i = 0; i < c_n_cnt; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (w_inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Display select
    logic [CNT_W-1:0] disp_q, disp_d;

    always_comb begin
        disp_d = '0;
        case (sel)
            c_sel_scl:   disp_d = cnt_q[c_idx_scl];
            c_sel_sda:   disp_d = cnt_q[c_idx_sda];
            c_sel_start: disp_d = cnt_q[c_idx_start];
            c_sel_stop:  disp_d = cnt_q[c_idx_stop];
            c_sel_byte:  disp_d = cnt_q[c_idx_byte];
            c_sel_nack:  disp_d = cnt_q[c_idx_nack];
            c_sel_addr:  disp_d = CNT_W'({addr_q, last_byte_q});
            default:     disp_d = cnt_q[c_idx_err];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_scl_q     <= 1'b1;
            p_sda_q     <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            rose_q      <= 1'b0;
            shreg_q     <= 8'h00;
            addr_q      <= 8'h00;
            first_q     <= 1'b0;
            last_byte_q <= 8'h00;
            last_ack_q  <= 1'b1;
            busy_q      <= 1'b0;
            byte_stb_q  <= 1'b0;
            disp_q      <= '0;
            for (int i = 0; i < c_n_cnt; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            p_scl_q     <= w_f_scl;
            p_sda_q     <= w_f_sda;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rose_q      <= rose_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            first_q     <= first_d;
            last_byte_q <= last_byte_d;
            last_ack_q  <= last_ack_d;
            busy_q      <= busy_d;
            byte_stb_q  <= byte_stb_d;
            disp_q      <= disp_d;
            for (int i = 0; i < c_n_cnt; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < CNT_W/4; g++) begin : g_dig
        enc7led u_enc (
            .din   (disp_q[4*g +: 4]),
            .enchx (1'b1),
            .seg   (hxled[7*g +: 7])
        );
    end

    assign disp_val  = disp_q;
    assign bus_busy  = busy_q;
    assign byte_stb  = byte_stb_q;
    assign last_byte = last_byte_q;
    assign last_ack  = last_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bus_monitor
// Description : Directed self-checking bench for i2c_bus_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_monitor;

    localparam int CNT_W = 16;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 scl   = 1'b1;
    logic                 sda   = 1'b1;
    logic                 clr   = 1'b0;
    logic [2:0]           sel   = 3'd0;
    logic [CNT_W-1:0]     disp_val;
    logic [CNT_W/4*7-1:0] hxled;
    logic                 bus_busy;
    logic                 byte_stb;
    logic [7:0]           last_byte;
    logic                 last_ack;

    int n_chk = 0;
    int n_fail = 0;
    int n_stb = 0;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2), .FILT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .sel       (sel),
        .clr       (clr),
        .disp_val  (disp_val),
        .hxled     (hxled),
        .bus_busy  (bus_busy),
        .byte_stb  (byte_stb),
        .last_byte (last_byte),
        .last_ack  (last_ack)
    );

    // byte_stb is one cycle wide, so it is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (byte_stb === 1'b1) n_stb <= n_stb + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold();
        tick(6);
    endtask

    task automatic chk_sel(input string tag, input logic [2:0] s, input logic [31:0] exp);
        sel = s;
        tick(2);
        chk(tag, 32'(disp_val), exp);
    endtask

    task automatic bit_out(input logic b);
        sda = b; hold();
        scl = 1'b1; hold();
        scl = 1'b0; hold();
    endtask

    task automatic i2c_start();
        sda = 1'b1; hold();
        scl = 1'b1; hold();
        sda = 1'b0; hold();
        scl = 1'b0; hold();
    endtask

    task automatic i2c_stop();
        sda = 1'b0; hold();
        scl = 1'b1; hold();
        sda = 1'b1; hold();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_out(ack);
    endtask

    task automatic pulse(input logic is_scl, input int n);
        if (is_scl) scl = 1'b0; else sda = 1'b0;
        tick(n);
        if (is_scl) scl = 1'b1; else sda = 1'b1;
        tick(10);
    endtask

    initial begin
        // Reset state
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_disp", 32'(disp_val), 32'h0);
        chk("rst_ack", 32'(last_ack), 32'h1);
        chk("rst_busy", 32'(bus_busy), 32'h0);
        chk("rst_stb", 32'(byte_stb), 32'h0);
        chk("rst_lbyte", 32'(last_byte), 32'h0);
        chk("rst_hxled", 32'(hxled), 32'({4{7'h3F}}));

        // Write A0 (ACK), 5A (NACK)
        i2c_start();
        chk("busy_mid", 32'(bus_busy), 32'h1);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h5A, 1'b1);
        i2c_stop();
        chk("busy_after", 32'(bus_busy), 32'h0);
        chk_sel("capture", 3'd6, 32'hA05A);
        chk("hx_capture", 32'(hxled), 32'({7'h77, 7'h3F, 7'h6D, 7'h77}));
        chk_sel("bytes", 3'd4, 32'd2);
        chk_sel("nacks", 3'd5, 32'd1);
        chk_sel("starts", 3'd2, 32'd1);
        chk_sel("stops", 3'd3, 32'd1);
        chk_sel("scl_rises", 3'd0, 32'd19);
        chk_sel("sda_rises", 3'd1, 32'd7);
        chk_sel("errors", 3'd7, 32'd0);
        chk("stb_count", 32'(n_stb), 32'd2);
        chk("last_byte", 32'(last_byte), 32'h5A);
        chk("last_ack", 32'(last_ack), 32'h1);

        // Glitches of 1 and FILT-1 clocks on both lines
        pulse(1'b1, 1);
        pulse(1'b1, 2);
        pulse(1'b0, 1);
        pulse(1'b0, 2);
        chk_sel("gl_scl", 3'd0, 32'd19);
        chk_sel("gl_sda", 3'd1, 32'd7);
        chk_sel("gl_start", 3'd2, 32'd1);
        chk_sel("gl_stop", 3'd3, 32'd1);
        chk_sel("gl_err", 3'd7, 32'd0);
        chk("gl_busy", 32'(bus_busy), 32'h0);

        // Repeated START after 3 data bits
        clr = 1'b1; tick(1); clr = 1'b0;
        chk_sel("clr_start", 3'd2, 32'd0);
        i2c_start();
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
        i2c_start();
        chk("rs_busy", 32'(bus_busy), 32'h1);
        i2c_stop();
        chk_sel("rs_starts", 3'd2, 32'd2);
        chk_sel("rs_errors", 3'd7, 32'd1);
        chk_sel("rs_bytes", 3'd4, 32'd0);
        chk_sel("rs_stops", 3'd3, 32'd1);
        chk("rs_stb", 32'(n_stb), 32'd2);

        // clr coincident with an SCL rise; then rise latency
        sel = 3'd0;
        clr = 1'b1; tick(1); clr = 1'b0;
        scl = 1'b0; tick(10);
        scl = 1'b1;
        tick(5);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        chk("clr_prio", 32'(disp_val), 32'd0);
        tick(3);
        chk("clr_hold", 32'(disp_val), 32'd0);
        scl = 1'b0; tick(10);
        scl = 1'b1;
        tick(6);
        chk("lat_before", 32'(disp_val), 32'd0);
        tick(1);
        chk("lat_after", 32'(disp_val), 32'd1);
        tick(4);

        // Reset in the middle of a byte
        i2c_start();
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
        sda = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("mr_disp", 32'(disp_val), 32'd0);
        chk("mr_busy", 32'(bus_busy), 32'h0);
        chk("mr_ack", 32'(last_ack), 32'h1);
        tick(10);
        i2c_stop();
        i2c_start();
        send_byte(8'h3C, 1'b0);
        i2c_stop();
        chk_sel("mr_errors", 3'd7, 32'd0);
        chk_sel("mr_bytes", 3'd4, 32'd1);
        chk_sel("mr_starts", 3'd2, 32'd1);
        chk_sel("mr_stops", 3'd3, 32'd2);
        chk_sel("mr_capture", 3'd6, 32'h3C3C);
        chk("mr_last_ack", 32'(last_ack), 32'h0);

        // Saturation: one SCL rise per clock for 2^16+5 clocks
        sel = 3'd0;
        clr = 1'b1; tick(1); clr = 1'b0;
        tick(1);
        force dut.w_scl_rise = 1'b1;
        tick(65541);
        release dut.w_scl_rise;
        tick(3);
        chk("sat_cnt", 32'(disp_val), 32'hFFFF);
        chk("sat_hxled", 32'(hxled), 32'({4{7'h71}}));
        scl = 1'b0; tick(10);
        scl = 1'b1; tick(10);
        chk("sat_hold", 32'(disp_val), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
